// File: rtl/node_issue_scheduler.sv
// Per-node issue scheduler: picks one fire-ready reservation-station frame in oldest-first
// rotating order, offers it to the ALU over valid/ready, and tracks per-frame issue history.
module node_issue_scheduler #(
  parameter int unsigned FRAMES      = 8,
  parameter int unsigned STALL_LIMIT = 64,
  localparam int unsigned FW         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_en,
  input  logic [FRAMES-1:0] frame_ready,
  input  logic [FRAMES-1:0] frame_flush,
  input  logic [FW-1:0]     oldest_frame,
  input  logic              alu_ready,
  output logic              issue_valid,
  output logic [FW-1:0]     issue_frame,
  output logic [FRAMES-1:0] fire_ack,
  output logic [FRAMES-1:0] issued_mask,
  output logic              stall_err,
  output logic [15:0]       issue_count
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {StIdle, StOffer} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     issue_frame_q, issue_frame_d;
  logic [FRAMES-1:0] fire_ack_q, fire_ack_d;
  logic [FRAMES-1:0] issued_mask_q, issued_mask_d;
  logic [15:0]       issue_count_q, issue_count_d;
  logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
  logic              stall_err_q, stall_err_d;

  logic [FRAMES-1:0] eligible;
  logic [FRAMES-1:0] frame_oh;
  logic [FW:0]       sel_new;
  logic [FW:0]       sel_b2b;

  // Returns {found, index}; scan starts at head and wraps modulo FRAMES, not 2^FW.
  function automatic logic [FW:0] pick_frame(input logic [FRAMES-1:0] elig,
                                             input logic [FW-1:0]     head);
    int unsigned start;
    int unsigned idx;
    logic [FW:0] res;
    res   = '0;
    start = (32'(head) >= FRAMES) ? 32'd0 : 32'(head);
    for (int unsigned i = 0; i < FRAMES; i++) begin
      idx = start + i;
      if (idx >= FRAMES) idx = idx - FRAMES;
      if (!res[FW] && elig[idx]) res = {1'b1, idx[FW-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    eligible = frame_ready & ~issued_mask_q & ~frame_flush;
    frame_oh = '0;
    frame_oh[issue_frame_q] = 1'b1;
    sel_new  = pick_frame(eligible, oldest_frame);
    sel_b2b  = pick_frame(eligible & ~frame_oh, oldest_frame);
  end

  always_comb begin
    state_d       = state_q;
    issue_frame_d = issue_frame_q;
    fire_ack_d    = '0;
    issued_mask_d = issued_mask_q;
    issue_count_d = issue_count_q;
    stall_cnt_d   = '0;
    stall_err_d   = stall_err_q;

    unique case (state_q)
      StIdle: begin
        if (sched_en && sel_new[FW]) begin
          state_d       = StOffer;
          issue_frame_d = sel_new[FW-1:0];
        end
      end
      StOffer: begin
        if (alu_ready) begin
          fire_ack_d    = frame_oh;
          issued_mask_d = issued_mask_q | frame_oh;
          issue_count_d = issue_count_q + 16'd1;
          if (sched_en && sel_b2b[FW]) begin
            issue_frame_d = sel_b2b[FW-1:0];
          end else begin
            state_d = StIdle;
          end
        end else if (frame_flush[issue_frame_q]) begin
          state_d = StIdle;
        end else begin
          // Offer held; count towards the stall timeout, saturating at the limit.
          stall_cnt_d = (stall_cnt_q == CW'(STALL_LIMIT)) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A flush always wins over a same-cycle accept for the history bit.
    issued_mask_d = issued_mask_d & ~frame_flush;
    if (stall_cnt_d == CW'(STALL_LIMIT)) stall_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      issue_frame_q <= '0;
      fire_ack_q    <= '0;
      issued_mask_q <= '0;
      issue_count_q <= '0;
      stall_cnt_q   <= '0;
      stall_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_frame_q <= issue_frame_d;
      fire_ack_q    <= fire_ack_d;
      issued_mask_q <= issued_mask_d;
      issue_count_q <= issue_count_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_err_q   <= stall_err_d;
    end
  end

  assign issue_valid = (state_q == StOffer);
  assign issue_frame = issue_frame_q;
  assign fire_ack    = fire_ack_q;
  assign issued_mask = issued_mask_q;
  assign stall_err   = stall_err_q;
  assign issue_count = issue_count_q;

endmodule
